// File: rtl/holy_axi_arbiter_if.sv
// AXI4 bundle shared by the cache-side requesters and the core's single master port.
// Every port carries the full channel set; read-only requesters leave the write side idle.
interface holy_axi_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/holy_axi_arbiter.sv
// Shares one AXI4 master port between the i-cache (s0, read-only) and d-cache (s1).
// One transaction in flight; the grant is held from address handshake to final response.
module holy_axi_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    holy_axi_arbiter_if.slave    s0,
    holy_axi_arbiter_if.slave    s1,
    holy_axi_arbiter_if.master   m_axi,
    output logic                 err_wlast
);

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [2:0] {IDLE, AR0, R0, AR1, R1, AW, W, B} state_t;

    state_t     state;
    logic       last_grant;   // 0 = s0 won last, 1 = s1 won last
    logic [7:0] len_q;
    logic [7:0] beat_cnt;

    logic req0, req1, last_beat;
    logic ar_hs, r_done, aw_hs, w_hs, b_hs;

    assign req0      = s0.arvalid;
    assign req1      = s1.awvalid | s1.arvalid;
    assign last_beat = (beat_cnt == len_q);

    assign ar_hs  = m_axi.arvalid & m_axi.arready;
    assign r_done = m_axi.rvalid & m_axi.rready & m_axi.rlast;
    assign aw_hs  = m_axi.awvalid & m_axi.awready;
    assign w_hs   = m_axi.wvalid & m_axi.wready;
    assign b_hs   = m_axi.bvalid & m_axi.bready;

    // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            len_q      <= '0;
            beat_cnt   <= '0;
            err_wlast  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req1 && (!req0 || !last_grant)) begin
                        last_grant <= 1'b1;
                        state      <= s1.awvalid ? AW : AR1;
                    end else if (req0) begin
                        last_grant <= 1'b0;
                        state      <= AR0;
                    end
                end
                AR0: if (ar_hs) state <= R0;
                AR1: if (ar_hs) state <= R1;
                R0, R1: if (r_done) state <= IDLE;
                AW: begin
                    if (aw_hs) begin
                        len_q    <= s1.awlen;
                        beat_cnt <= '0;
                        state    <= W;
                    end
                end
                W: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (s1.wlast != last_beat) err_wlast <= 1'b1;
                        if (last_beat) state <= B;
                    end
                end
                B: if (b_hs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every driven signal gets a default first so no path can infer a latch.
        s0.awready = 1'b0; s0.wready = 1'b0;
        s0.bid = '0; s0.bresp = '0; s0.bvalid = 1'b0;
        s0.arready = 1'b0;
        s0.rid = '0; s0.rdata = '0; s0.rresp = '0; s0.rlast = 1'b0; s0.rvalid = 1'b0;

        s1.awready = 1'b0; s1.wready = 1'b0;
        s1.bid = '0; s1.bresp = '0; s1.bvalid = 1'b0;
        s1.arready = 1'b0;
        s1.rid = '0; s1.rdata = '0; s1.rresp = '0; s1.rlast = 1'b0; s1.rvalid = 1'b0;

        m_axi.awid = '0; m_axi.awaddr = '0; m_axi.awlen = '0;
        m_axi.awsize = '0; m_axi.awburst = '0; m_axi.awvalid = 1'b0;
        m_axi.wdata = '0; m_axi.wstrb = '0; m_axi.wlast = 1'b0; m_axi.wvalid = 1'b0;
        m_axi.bready = 1'b0;
        m_axi.arid = '0; m_axi.araddr = '0; m_axi.arlen = '0;
        m_axi.arsize = '0; m_axi.arburst = '0; m_axi.arvalid = 1'b0;
        m_axi.rready = 1'b0;

        unique case (state)
            AR0: begin
                m_axi.arid    = '0;
                m_axi.araddr  = s0.araddr;
                m_axi.arlen   = s0.arlen;
                m_axi.arsize  = AXI_SIZE_4B;
                m_axi.arburst = AXI_BURST_INCR;
                m_axi.arvalid = s0.arvalid;
                s0.arready    = m_axi.arready;
            end
            AR1: begin
                m_axi.arid    = ID_WIDTH'(1);
                m_axi.araddr  = s1.araddr;
                m_axi.arlen   = s1.arlen;
                m_axi.arsize  = AXI_SIZE_4B;
                m_axi.arburst = AXI_BURST_INCR;
                m_axi.arvalid = s1.arvalid;
                s1.arready    = m_axi.arready;
            end
            // Routing follows the grant, not rid.
            R0: begin
                s0.rid       = m_axi.rid;
                s0.rdata     = m_axi.rdata;
                s0.rresp     = m_axi.rresp;
                s0.rlast     = m_axi.rlast;
                s0.rvalid    = m_axi.rvalid;
                m_axi.rready = s0.rready;
            end
            R1: begin
                s1.rid       = m_axi.rid;
                s1.rdata     = m_axi.rdata;
                s1.rresp     = m_axi.rresp;
                s1.rlast     = m_axi.rlast;
                s1.rvalid    = m_axi.rvalid;
                m_axi.rready = s1.rready;
            end
            AW: begin
                m_axi.awid    = ID_WIDTH'(1);
                m_axi.awaddr  = s1.awaddr;
                m_axi.awlen   = s1.awlen;
                m_axi.awsize  = AXI_SIZE_4B;
                m_axi.awburst = AXI_BURST_INCR;
                m_axi.awvalid = s1.awvalid;
                s1.awready    = m_axi.awready;
            end
            // wlast comes from the beat counter so a misbehaving cache cannot truncate the burst.
            W: begin
                m_axi.wdata  = s1.wdata;
                m_axi.wstrb  = s1.wstrb;
                m_axi.wlast  = last_beat;
                m_axi.wvalid = s1.wvalid;
                s1.wready    = m_axi.wready;
            end
            B: begin
                s1.bid       = m_axi.bid;
                s1.bresp     = m_axi.bresp;
                s1.bvalid    = m_axi.bvalid;
                m_axi.bready = s1.bready;
            end
            default: ;
        endcase
    end

    // Requester-side fields the arbiter overrides or never uses.
    logic unused_inputs;
    assign unused_inputs = ^{s0.awid, s0.awaddr, s0.awlen, s0.awsize, s0.awburst, s0.awvalid,
                             s0.wdata, s0.wstrb, s0.wlast, s0.wvalid, s0.bready,
                             s0.arid, s0.arsize, s0.arburst,
                             s1.arid, s1.arsize, s1.arburst,
                             s1.awid, s1.awsize, s1.awburst};

endmodule

// File: tb/tb_holy_axi_arbiter.sv
// Self-checking bench for holy_axi_arbiter: scenario tasks with randomized stimulus
// checked against a transaction-level round-robin model.
module tb_holy_axi_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst;
    logic err_wlast;

    always #5 clk = ~clk;

    holy_axi_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) s0_bus ();
    holy_axi_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) s1_bus ();
    holy_axi_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) m_bus ();

    holy_axi_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s0        (s0_bus),
        .s1        (s1_bus),
        .m_axi     (m_bus),
        .err_wlast (err_wlast)
    );

    int checks   = 0;
    int failures = 0;
    int last_g   = 1;     // model: requester granted most recently
    bit err_exp  = 1'b0;  // model: sticky wlast-mismatch flag

    // Round-robin rule: a tie goes to whoever did not win last time.
    function automatic int pick(input bit r0, input bit r1);
        int w;
        if (r0 && r1) w = (last_g == 1) ? 0 : 1;
        else          w = r0 ? 0 : 1;
        last_g = w;
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s0_bus.awid = '0; s0_bus.awaddr = '0; s0_bus.awlen = '0; s0_bus.awsize = '0;
        s0_bus.awburst = '0; s0_bus.awvalid = 0; s0_bus.wdata = '0; s0_bus.wstrb = '0;
        s0_bus.wlast = 0; s0_bus.wvalid = 0; s0_bus.bready = 0; s0_bus.arid = '0;
        s0_bus.araddr = '0; s0_bus.arlen = '0; s0_bus.arsize = '0; s0_bus.arburst = '0;
        s0_bus.arvalid = 0; s0_bus.rready = 0;
        s1_bus.awid = '0; s1_bus.awaddr = '0; s1_bus.awlen = '0; s1_bus.awsize = '0;
        s1_bus.awburst = '0; s1_bus.awvalid = 0; s1_bus.wdata = '0; s1_bus.wstrb = '0;
        s1_bus.wlast = 0; s1_bus.wvalid = 0; s1_bus.bready = 0; s1_bus.arid = '0;
        s1_bus.araddr = '0; s1_bus.arlen = '0; s1_bus.arsize = '0; s1_bus.arburst = '0;
        s1_bus.arvalid = 0; s1_bus.rready = 0;
        m_bus.awready = 0; m_bus.wready = 0; m_bus.bid = '0; m_bus.bresp = '0;
        m_bus.bvalid = 0; m_bus.arready = 0; m_bus.rid = '0; m_bus.rdata = '0;
        m_bus.rresp = '0; m_bus.rlast = 0; m_bus.rvalid = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        // Requests and slave readiness present during reset must not leak through.
        s0_bus.arvalid = 1; s1_bus.awvalid = 1; m_bus.arready = 1; m_bus.wready = 1;
        #1;
        checks++;
        if ({m_bus.arvalid, m_bus.awvalid, m_bus.wvalid, m_bus.rready, m_bus.bready,
             s0_bus.arready, s0_bus.rvalid, s1_bus.arready, s1_bus.awready, s1_bus.wready,
             s1_bus.rvalid, s1_bus.bvalid, err_wlast} !== 13'b0) begin
            failures++;
            $display("FAIL reset_outputs: got valids/readies/err=%b expected all zero",
                     {m_bus.arvalid, m_bus.awvalid, m_bus.wvalid, m_bus.rready, m_bus.bready,
                      s0_bus.arready, s0_bus.rvalid, s1_bus.arready, s1_bus.awready,
                      s1_bus.wready, s1_bus.rvalid, s1_bus.bvalid, err_wlast});
        end
        clear_inputs();
        step();
        rst = 1'b0;
        last_g  = 1;
        err_exp = 1'b0;
        step();
    endtask

    // Serves one read for requester `who` whose AR request is already being presented.
    task automatic read_txn(input int who, input logic [AW-1:0] addr, input logic [7:0] len);
        bit found = 0;
        bit hs;
        int n;
        logic [DW-1:0] d;
        logic [1:0] rr;
        logic rdy, v, other, l;
        logic [DW-1:0] rd;
        logic [1:0] rs;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (m_bus.arvalid === 1'b1) begin found = 1; break; end
            step();
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL ar_grant_%0d: got no arvalid within 8 cycles expected grant", who);
            return;
        end
        checks++;
        if ({m_bus.arid, m_bus.araddr, m_bus.arlen, m_bus.arsize, m_bus.arburst, m_bus.awvalid} !==
            {IW'(who), addr, len, 3'b010, 2'b01, 1'b0}) begin
            failures++;
            $display("FAIL ar_fields_%0d: got id=%0d addr=%h len=%0d size=%b burst=%b awv=%b expected id=%0d addr=%h len=%0d size=010 burst=01 awv=0",
                     who, m_bus.arid, m_bus.araddr, m_bus.arlen, m_bus.arsize, m_bus.arburst,
                     m_bus.awvalid, who, addr, len);
        end
        hs = 0;
        for (int k = 0; k < 16 && !hs; k++) begin
            m_bus.arready = (k == 15) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({s0_bus.arready, s1_bus.arready} !== ((who == 0) ? {m_bus.arready, 1'b0} : {1'b0, m_bus.arready})) begin
                failures++;
                $display("FAIL arready_route_%0d: got s0=%b s1=%b expected slave arready=%b on requester only",
                         who, s0_bus.arready, s1_bus.arready, m_bus.arready);
            end
            hs = m_bus.arready;
            step();
        end
        if (who == 0) s0_bus.arvalid = 0; else s1_bus.arvalid = 0;
        m_bus.arready = 0;

        n = 0;
        for (int k = 0; k < 200 && n <= int'(len); k++) begin
            m_bus.rvalid = ($urandom_range(0, 3) != 0);
            d = $urandom; rr = 2'($urandom); m_bus.rdata = d; m_bus.rresp = rr;
            m_bus.rlast = (n == int'(len));
            m_bus.rid = IW'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            if (who == 0) s0_bus.rready = rdy; else s1_bus.rready = rdy;
            #1;
            v     = (who == 0) ? s0_bus.rvalid : s1_bus.rvalid;
            other = (who == 0) ? s1_bus.rvalid : s0_bus.rvalid;
            rd    = (who == 0) ? s0_bus.rdata  : s1_bus.rdata;
            rs    = (who == 0) ? s0_bus.rresp  : s1_bus.rresp;
            l     = (who == 0) ? s0_bus.rlast  : s1_bus.rlast;
            checks++;
            if ({v, other, m_bus.rready} !== {m_bus.rvalid, 1'b0, rdy}) begin
                failures++;
                $display("FAIL r_route_%0d: got rvalid=%b other_rvalid=%b rready=%b expected %b 0 %b",
                         who, v, other, m_bus.rready, m_bus.rvalid, rdy);
            end
            if (m_bus.rvalid) begin
                checks++;
                if ({rd, rs, l} !== {d, rr, (n == int'(len))}) begin
                    failures++;
                    $display("FAIL r_data_%0d beat %0d: got data=%h resp=%b last=%b expected data=%h resp=%b last=%b",
                             who, n, rd, rs, l, d, rr, (n == int'(len)));
                end
            end
            hs = m_bus.rvalid & rdy;
            step();
            if (hs) n++;
        end
        checks++;
        if (n != int'(len) + 1) begin
            failures++;
            $display("FAIL r_beats_%0d: got %0d beats expected %0d", who, n, int'(len) + 1);
        end
        m_bus.rvalid = 0; m_bus.rlast = 0; s0_bus.rready = 0; s1_bus.rready = 0;
        #1;
        checks++;
        if ({m_bus.arvalid, m_bus.awvalid, s0_bus.rvalid, s1_bus.rvalid, s0_bus.arready, s1_bus.arready} !== 6'b0) begin
            failures++;
            $display("FAIL idle_after_read_%0d: got arv=%b awv=%b rv0=%b rv1=%b expected all zero in turnaround",
                     who, m_bus.arvalid, m_bus.awvalid, s0_bus.rvalid, s1_bus.rvalid);
        end
    endtask

    // Serves one s1 write whose AW request is already presented; bad_beat >= 0 puts
    // s1_wlast on that beat index instead of the real last one.
    task automatic write_txn(input logic [AW-1:0] addr, input logic [7:0] len, input int bad_beat,
                             input bit toggle, input logic [1:0] resp);
        bit found = 0;
        bit hs;
        int n;
        logic [DW-1:0] d;
        logic [DW/8-1:0] st;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (m_bus.awvalid === 1'b1) begin found = 1; break; end
            step();
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL aw_grant: got no awvalid within 8 cycles expected grant");
            return;
        end
        checks++;
        if ({m_bus.awid, m_bus.awaddr, m_bus.awlen, m_bus.awsize, m_bus.awburst, m_bus.arvalid} !==
            {IW'(1), addr, len, 3'b010, 2'b01, 1'b0}) begin
            failures++;
            $display("FAIL aw_fields: got id=%0d addr=%h len=%0d size=%b burst=%b arv=%b expected id=1 addr=%h len=%0d size=010 burst=01 arv=0",
                     m_bus.awid, m_bus.awaddr, m_bus.awlen, m_bus.awsize, m_bus.awburst,
                     m_bus.arvalid, addr, len);
        end
        hs = 0;
        s1_bus.wvalid = 1; m_bus.wready = 1;
        for (int k = 0; k < 16 && !hs; k++) begin
            m_bus.awready = (k == 15) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({s1_bus.awready, s1_bus.wready, m_bus.wvalid} !== {m_bus.awready, 2'b00}) begin
                failures++;
                $display("FAIL aw_phase: got awready=%b wready=%b m_wvalid=%b expected %b 0 0",
                         s1_bus.awready, s1_bus.wready, m_bus.wvalid, m_bus.awready);
            end
            hs = m_bus.awready;
            step();
        end
        s1_bus.awvalid = 0; m_bus.awready = 0;

        n = 0;
        for (int k = 0; k < 300 && n <= int'(len); k++) begin
            s1_bus.wvalid = ($urandom_range(0, 3) != 0);
            d = $urandom; st = DW/8'($urandom);
            s1_bus.wdata = d; s1_bus.wstrb = st;
            s1_bus.wlast = (bad_beat >= 0) ? (n == bad_beat) : (n == int'(len));
            m_bus.wready = toggle ? ((k % 2) == 0) : 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({m_bus.wvalid, s1_bus.wready, m_bus.wlast, m_bus.wdata, m_bus.wstrb, err_wlast} !==
                {s1_bus.wvalid, m_bus.wready, (n == int'(len)), d, st, err_exp}) begin
                failures++;
                $display("FAIL w_beat %0d: got wvalid=%b wready=%b wlast=%b data=%h strb=%h err=%b expected %b %b %b %h %h %b",
                         n, m_bus.wvalid, s1_bus.wready, m_bus.wlast, m_bus.wdata, m_bus.wstrb, err_wlast,
                         s1_bus.wvalid, m_bus.wready, (n == int'(len)), d, st, err_exp);
            end
            hs = s1_bus.wvalid & m_bus.wready;
            if (hs && (s1_bus.wlast != (n == int'(len)))) err_exp = 1'b1;
            step();
            if (hs) n++;
        end
        checks++;
        if (n != int'(len) + 1) begin
            failures++;
            $display("FAIL w_beats: got %0d handshakes expected %0d", n, int'(len) + 1);
        end

        hs = 0;
        s1_bus.wvalid = 1; m_bus.wready = 1; s1_bus.wlast = 0;
        m_bus.bresp = resp; m_bus.bid = IW'(1);
        for (int k = 0; k < 16 && !hs; k++) begin
            m_bus.bvalid  = (k == 15) ? 1'b1 : 1'($urandom_range(0, 1));
            s1_bus.bready = (k == 15) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({s1_bus.bvalid, s1_bus.bresp, m_bus.bready, m_bus.wvalid, s1_bus.wready, err_wlast} !==
                {m_bus.bvalid, resp, s1_bus.bready, 2'b00, err_exp}) begin
                failures++;
                $display("FAIL b_phase: got bvalid=%b bresp=%b bready=%b m_wvalid=%b wready=%b err=%b expected %b %b %b 0 0 %b",
                         s1_bus.bvalid, s1_bus.bresp, m_bus.bready, m_bus.wvalid, s1_bus.wready, err_wlast,
                         m_bus.bvalid, resp, s1_bus.bready, err_exp);
            end
            hs = m_bus.bvalid & s1_bus.bready;
            step();
        end
        s1_bus.wvalid = 0; m_bus.wready = 0; m_bus.bvalid = 0; s1_bus.bready = 0;
        #1;
        checks++;
        if ({m_bus.awvalid, m_bus.arvalid, m_bus.wvalid, s1_bus.bvalid, err_wlast} !== {4'b0, err_exp}) begin
            failures++;
            $display("FAIL idle_after_write: got awv=%b arv=%b wv=%b bv=%b err=%b expected 0 0 0 0 %b",
                     m_bus.awvalid, m_bus.arvalid, m_bus.wvalid, s1_bus.bvalid, err_wlast, err_exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({m_bus.arvalid, m_bus.awvalid, m_bus.wvalid, m_bus.rready, m_bus.bready, err_wlast} !== 6'b0) begin
            failures++;
            $display("FAIL post_reset_idle: got %b expected all zero",
                     {m_bus.arvalid, m_bus.awvalid, m_bus.wvalid, m_bus.rready, m_bus.bready, err_wlast});
        end
    endtask

    task automatic test_s0_read();
        do_reset();
        s0_bus.araddr = 32'h1000; s0_bus.arlen = 8'd3; s0_bus.arvalid = 1;
        #1;
        checks++;
        if (m_bus.arvalid !== 1'b0) begin
            failures++;
            $display("FAIL s0_grant_latency_n: got arvalid=%b expected 0 in request cycle", m_bus.arvalid);
        end
        step();
        #1;
        checks++;
        if (m_bus.arvalid !== 1'b1) begin
            failures++;
            $display("FAIL s0_grant_latency_n1: got arvalid=%b expected 1 one cycle later", m_bus.arvalid);
        end
        read_txn(pick(1, 0), 32'h1000, 8'd3);
    endtask

    task automatic test_simultaneous_reads();
        logic [AW-1:0] addr [2];
        logic [7:0]    len  [2];
        bit            pend [2];
        int w;
        do_reset();
        pend[0] = 0; pend[1] = 0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    addr[i] = {$urandom} & 32'hFFFF_FFFC;
                    len[i]  = 8'($urandom_range(0, 3));
                    pend[i] = 1;
                end
            end
            s0_bus.araddr = addr[0]; s0_bus.arlen = len[0]; s0_bus.arvalid = 1;
            s1_bus.araddr = addr[1]; s1_bus.arlen = len[1]; s1_bus.arvalid = 1;
            w = pick(1, 1);
            read_txn(w, addr[w], len[w]);
            pend[w] = 0;
        end
        s0_bus.arvalid = 0; s1_bus.arvalid = 0;
        step();
    endtask

    task automatic test_write_toggle();
        logic [AW-1:0] a;
        do_reset();
        a = {$urandom} & 32'hFFFF_FFFC;
        s1_bus.awaddr = a; s1_bus.awlen = 8'd7; s1_bus.awvalid = 1;
        void'(pick(0, 1));
        write_txn(a, 8'd7, -1, 1'b1, 2'b10);
    endtask

    task automatic test_wlast_error();
        logic [AW-1:0] a;
        do_reset();
        a = {$urandom} & 32'hFFFF_FFFC;
        s1_bus.awaddr = a; s1_bus.awlen = 8'd7; s1_bus.awvalid = 1;
        void'(pick(0, 1));
        write_txn(a, 8'd7, 2, 1'b0, 2'($urandom));
        step();
        #1;
        checks++;
        if (err_wlast !== 1'b1) begin
            failures++;
            $display("FAIL err_wlast_sticky: got %b expected 1", err_wlast);
        end
    endtask

    task automatic test_aw_priority();
        logic [AW-1:0] wa, ra;
        logic [7:0] wl, rl;
        do_reset();
        wa = {$urandom} & 32'hFFFF_FFFC; wl = 8'($urandom_range(0, 4));
        ra = {$urandom} & 32'hFFFF_FFFC; rl = 8'($urandom_range(0, 3));
        s1_bus.awaddr = wa; s1_bus.awlen = wl; s1_bus.awvalid = 1;
        s1_bus.araddr = ra; s1_bus.arlen = rl; s1_bus.arvalid = 1;
        void'(pick(0, 1));
        write_txn(wa, wl, -1, 1'b0, 2'b00);
        read_txn(pick(0, 1), ra, rl);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        s0_bus.araddr = 32'h2000; s0_bus.arlen = 8'd3; s0_bus.arvalid = 1;
        step();
        m_bus.arready = 1;
        step();
        s0_bus.arvalid = 0; m_bus.arready = 0;
        m_bus.rvalid = 1; m_bus.rdata = $urandom; s0_bus.rready = 1;
        step();
        m_bus.rdata = $urandom;
        #1;
        checks++;
        if (s0_bus.rvalid !== 1'b1) begin
            failures++;
            $display("FAIL mid_burst_precondition: got s0_rvalid=%b expected 1 on beat 2", s0_bus.rvalid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({m_bus.rready, m_bus.arvalid, s0_bus.rvalid} !== 3'b000) begin
            failures++;
            $display("FAIL async_reset_drop: got rready=%b arvalid=%b s0_rvalid=%b expected 0 0 0",
                     m_bus.rready, m_bus.arvalid, s0_bus.rvalid);
        end
        clear_inputs();
        step();
        rst = 1'b0;
        last_g = 1; err_exp = 0;
        step();
        s1_bus.araddr = 32'h3000; s1_bus.arlen = 8'd1; s1_bus.arvalid = 1;
        read_txn(pick(0, 1), 32'h3000, 8'd1);
    endtask

    task automatic test_random();
        bit r0, rr1, rw1;
        int w;
        logic [AW-1:0] a0, a1, aw;
        logic [7:0] l0, l1, lw;
        do_reset();
        for (int r = 0; r < 20; r++) begin
            r0 = 1'($urandom); rr1 = 1'($urandom); rw1 = 1'($urandom);
            if (!(r0 | rr1 | rw1)) r0 = 1;
            a0 = {$urandom} & 32'hFFFF_FFFC; l0 = 8'($urandom_range(0, 3));
            a1 = {$urandom} & 32'hFFFF_FFFC; l1 = 8'($urandom_range(0, 3));
            aw = {$urandom} & 32'hFFFF_FFFC; lw = 8'($urandom_range(0, 5));
            s0_bus.araddr = a0; s0_bus.arlen = l0; s0_bus.arvalid = r0;
            s1_bus.araddr = a1; s1_bus.arlen = l1; s1_bus.arvalid = rr1;
            s1_bus.awaddr = aw; s1_bus.awlen = lw; s1_bus.awvalid = rw1;
            w = pick(r0, rr1 | rw1);
            if (w == 0)   read_txn(0, a0, l0);
            else if (rw1) write_txn(aw, lw, -1, 1'b0, 2'($urandom));
            else          read_txn(1, a1, l1);
            s0_bus.arvalid = 0; s1_bus.arvalid = 0; s1_bus.awvalid = 0;
        end
        step();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_s0_read();
        test_simultaneous_reads();
        test_write_toggle();
        test_wlast_error();
        test_aw_priority();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
